// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
// A bubble is inserted when the instruction in ID needs the result of a
// load that is currently in EX. A taken branch (Flush) also loads a bubble,
// and a downstream freeze (Hold) stops the whole register.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [XLEN-1:0]  ID_PC,
  input  logic [XLEN-1:0]  ID_RData1,
  input  logic [XLEN-1:0]  ID_RData2,
  input  logic [XLEN-1:0]  ID_Imm,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic [4:0]       ID_Rd,
  input  logic             ID_UsesRs1,
  input  logic             ID_UsesRs2,
  input  logic             ID_Valid,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             ID_MemWrite,
  input  logic             ID_MemtoReg,
  input  logic             ID_ALUSrc,
  input  logic             ID_Branch,
  input  logic [1:0]       ID_ALUOp,
  input  logic             Flush,
  input  logic             Hold,
  output logic [XLEN-1:0]  IDEX_PC,
  output logic [XLEN-1:0]  IDEX_RData1,
  output logic [XLEN-1:0]  IDEX_RData2,
  output logic [XLEN-1:0]  IDEX_Imm,
  output logic [4:0]       IDEX_Rs1,
  output logic [4:0]       IDEX_Rs2,
  output logic [4:0]       IDEX_Rd,
  output logic             IDEX_RegWrite,
  output logic             IDEX_MemRead,
  output logic             IDEX_MemWrite,
  output logic             IDEX_MemtoReg,
  output logic             IDEX_ALUSrc,
  output logic             IDEX_Branch,
  output logic [1:0]       IDEX_ALUOp,
  output logic             IDEX_Valid,
  output logic             Stall,
  output logic [CNT_W-1:0] BubbleCount
);

  logic [XLEN-1:0]  r_pc, r_rdata1, r_rdata2, r_imm;
  logic [4:0]       r_rs1, r_rs2, r_rd;
  logic             r_regWrite, r_memRead, r_memWrite, r_memtoReg;
  logic             r_aluSrc, r_branch, r_valid;
  logic [1:0]       r_aluOp;
  logic [CNT_W-1:0] r_count;

  logic w_loadUse;
  logic w_bubble;
  logic w_countInc;
  logic w_rs1Hit;
  logic w_rs2Hit;

  localparam logic [CNT_W-1:0] CountMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CountOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Hazard detection: a valid load in EX whose non-zero destination is read by ID
  always_comb begin
    w_rs1Hit   = ID_UsesRs1 && (ID_Rs1 == r_rd);
    w_rs2Hit   = ID_UsesRs2 && (ID_Rs2 == r_rd);
    w_loadUse  = r_valid && r_memRead && (r_rd != 5'd0) && ID_Valid &&
                 (w_rs1Hit || w_rs2Hit);
    w_bubble   = Flush || w_loadUse;
    w_countInc = w_loadUse && !Flush;
    Stall      = Hold || (w_loadUse && !Flush);
  end

  // Pipeline register: Hold freezes, Flush/LoadUse load a bubble, else capture ID
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= '0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_regWrite <= 1'b0;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      r_memtoReg <= 1'b0;
      r_aluSrc   <= 1'b0;
      r_branch   <= 1'b0;
      r_aluOp    <= 2'b00;
      r_valid    <= 1'b0;
    end else if (!Hold) begin
      // Data fields follow ID even for a bubble; only control is squashed.
      r_pc     <= ID_PC;
      r_rdata1 <= ID_RData1;
      r_rdata2 <= ID_RData2;
      r_imm    <= ID_Imm;
      if (w_bubble) begin
        r_rs1      <= '0;
        r_rs2      <= '0;
        r_rd       <= '0;
        r_regWrite <= 1'b0;
        r_memRead  <= 1'b0;
        r_memWrite <= 1'b0;
        r_memtoReg <= 1'b0;
        r_aluSrc   <= 1'b0;
        r_branch   <= 1'b0;
        r_aluOp    <= 2'b00;
        r_valid    <= 1'b0;
      end else begin
        r_rs1      <= ID_Rs1;
        r_rs2      <= ID_Rs2;
        r_rd       <= ID_Rd;
        r_regWrite <= ID_RegWrite;
        r_memRead  <= ID_MemRead;
        r_memWrite <= ID_MemWrite;
        r_memtoReg <= ID_MemtoReg;
        r_aluSrc   <= ID_ALUSrc;
        r_branch   <= ID_Branch;
        r_aluOp    <= ID_ALUOp;
        r_valid    <= ID_Valid;
      end
    end
  end

  // Saturating count of load-use bubbles; flush bubbles are not counted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (!Hold && w_countInc && (r_count != CountMax)) begin
      r_count <= r_count + CountOne;
    end
  end

  assign IDEX_PC       = r_pc;
  assign IDEX_RData1   = r_rdata1;
  assign IDEX_RData2   = r_rdata2;
  assign IDEX_Imm      = r_imm;
  assign IDEX_Rs1      = r_rs1;
  assign IDEX_Rs2      = r_rs2;
  assign IDEX_Rd       = r_rd;
  assign IDEX_RegWrite = r_regWrite;
  assign IDEX_MemRead  = r_memRead;
  assign IDEX_MemWrite = r_memWrite;
  assign IDEX_MemtoReg = r_memtoReg;
  assign IDEX_ALUSrc   = r_aluSrc;
  assign IDEX_Branch   = r_branch;
  assign IDEX_ALUOp    = r_aluOp;
  assign IDEX_Valid    = r_valid;
  assign BubbleCount   = r_count;

endmodule
